cnt_arb: RTL and testbench
==========================

CNT_ARB -- requirements
Module: cnt_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter and modulus width in bits.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-003 SHALL have port sys_clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port sys_rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req, input, NREQ, per-requester level request; held high until done or abandon.
REQ-006 SHALL have port model_in, input, NREQ*WIDTH, per-requester modulus; slice i is bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port grant, output, NREQ, one-hot owner of the shared counter; all zero when free.
REQ-008 SHALL have port busy, output, 1, high in RUN and DONE states.
REQ-009 SHALL have port cnt, output, WIDTH, current value of the shared modulo counter.
REQ-010 SHALL have port done, output, NREQ, one-cycle pulse to the requester whose count completed.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE, registered.
REQ-012 IDLE: with req == 0, stay IDLE; cnt = 0, grant = 0.
REQ-013 IDLE: with any req bit high, select the winner round-robin, searching from index ptr+1 upward with wrap to 0.
REQ-014 On that edge: grant <= one-hot winner, latch m <= model_in slice of the winner, cnt <= 0, state <= RUN.
REQ-015 Latency: req high in IDLE -> grant high on the next edge.
REQ-016 The latched m SHALL be stable for the whole job; model_in changes after grant have no effect.
REQ-017 m == 0 SHALL mean modulus 2^WIDTH.
REQ-018 m == 1 SHALL give a one-cycle job, with cnt == 0 immediately terminal.
REQ-019 RUN: each cycle cnt <= cnt+1, mod 2^WIDTH.
REQ-020 RUN: when cnt == m-1 (WIDTH-bit compare), cnt <= 0, grant <= 0, done[winner] <= 1, state <= DONE.
REQ-021 DONE: lasts exactly one cycle; done deasserts; ptr <= winner index; state <= IDLE.
REQ-022 Job throughput: m+2 cycles from grant edge to the next possible grant edge.
REQ-023 Abandon: if req[winner] falls during RUN, then on the next edge grant <= 0, cnt <= 0, ptr <= winner, state <= IDLE, and no done pulse.
REQ-024 Abandon takes priority over a terminal count on the same edge.
REQ-025 Requests from non-winners during RUN/DONE SHALL be ignored until IDLE, never lost while held.
REQ-026 At most one grant bit and at most one done bit SHALL be high in any cycle.

Reset
REQ-027 sys_rst high SHALL immediately force state = IDLE, cnt = 0, grant = 0, done = 0, busy = 0, m = 0, ptr = NREQ-1, so requester 0 wins first.
REQ-028 Reset asserted mid-RUN SHALL abort the job with no done pulse.
REQ-029 After reset deassertion, the first arbitration SHALL occur on the first rising edge with req != 0.

Structure
REQ-030 Package cnt_arb_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and default WIDTH/NREQ constants.
REQ-031 Round-robin selection SHALL be a separate combinational sub-module rr_pick (inputs req, ptr; output one-hot winner plus index).
REQ-032 The counter datapath SHALL stay inline in cnt_arb.

Verification
REQ-033 WIDTH=4, NREQ=4, req=0001, m0=5 -> grant=0001 one edge later; cnt 0,1,2,3,4; done=0001 for one cycle; grant=0 at done.
REQ-034 req=1111 held, all m=2 -> grant order 0001,0010,0100,1000,0001; each job 4 cycles edge-to-edge.
REQ-035 req=0100, m2=0 -> cnt runs 0..15; done after 16 RUN cycles; no early wrap.
REQ-036 req=0010, m1=1 -> one RUN cycle at cnt=0, then done=0010.
REQ-037 req0 drops at cnt=2 with m0=6 -> no done; IDLE next edge; pending req1 granted on the following edge.
REQ-038 sys_rst pulsed asynchronously mid-RUN at cnt=3 -> outputs zero before the next clock edge; requester 0 wins after release.

Source files
------------

// File: rtl/cnt_arb_pkg.sv
// rtl/cnt_arb_pkg.sv - shared FSM state encoding and default sizes for the counter arbiter
package cnt_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREQ  = 4;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick, searching upward from ptr+1 with wrap
module rr_pick
  import cnt_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = $clog2(DEF_NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] winner,
  output logic [IW-1:0]   idx,
  output logic            found
);

  logic [IW-1:0] w_cand;

  // The last owner (ptr) is visited last, so it only wins again when nobody else asks.
  always_comb begin
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    w_cand = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IW'((int'(ptr) + k) % NREQ);
      if (!found && req[w_cand]) begin
        found          = 1'b1;
        winner[w_cand] = 1'b1;
        idx            = w_cand;
      end
    end
  end

endmodule

// File: rtl/cnt_arb.sv
// rtl/cnt_arb.sv - round-robin arbiter lending one shared modulo counter to NREQ requesters
module cnt_arb
  import cnt_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] model_in,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic [WIDTH-1:0]      cnt,
  output logic [NREQ-1:0]       done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            r_state;
  state_t            w_next;
  logic [NREQ-1:0]   r_grant;
  logic [NREQ-1:0]   r_done;
  logic [IW-1:0]     r_idx;
  logic [IW-1:0]     r_ptr;
  logic [WIDTH-1:0]  r_cnt;
  logic [WIDTH-1:0]  r_m;
  logic [NREQ-1:0]   w_win;
  logic [IW-1:0]     w_win_idx;
  logic              w_found;
  logic [WIDTH-1:0]  w_win_m;
  logic              w_term;
  logic              w_abandon;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req    (req),
    .ptr    (r_ptr),
    .winner (w_win),
    .idx    (w_win_idx),
    .found  (w_found)
  );

  assign w_win_m = model_in[w_win_idx*WIDTH +: WIDTH];
  // m == 0 wraps m-1 to all ones, giving the full 2^WIDTH modulus for free.
  assign w_term    = (r_cnt == (r_m - WIDTH'(1)));
  assign w_abandon = ~req[r_idx];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_found) w_next = RUN;
      RUN: begin
        if (w_abandon)   w_next = IDLE;
        else if (w_term) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_grant <= '0;
      r_done  <= '0;
      r_idx   <= '0;
      r_ptr   <= IW'(NREQ - 1);
      r_cnt   <= '0;
      r_m     <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_found) begin
            r_grant <= w_win;
            r_idx   <= w_win_idx;
            r_m     <= w_win_m;
          end
        end
        RUN: begin
          // Abandon outranks a terminal count on the same edge.
          if (w_abandon) begin
            r_grant <= '0;
            r_cnt   <= '0;
            r_ptr   <= r_idx;
          end else if (w_term) begin
            r_grant <= '0;
            r_cnt   <= '0;
            r_done  <= r_grant;
          end else begin
            r_cnt <= r_cnt + WIDTH'(1);
          end
        end
        DONE: r_ptr <= r_idx;
        default: begin
          r_grant <= '0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign grant = r_grant;
  assign done  = r_done;
  assign cnt   = r_cnt;
  assign busy  = (r_state != IDLE);

endmodule

// File: tb/tb_cnt_arb.sv
// tb/tb_cnt_arb.sv - self-checking bench for cnt_arb: directed scenarios plus randomized model compare
module tb_cnt_arb;

  localparam int W = 4;
  localparam int N = 4;

  logic           sys_clk;
  logic           sys_rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] model_in;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic [W-1:0]   cnt;

  int n_tests = 0;
  int n_fail  = 0;

  int m_owner, m_k, m_mod, m_ptr, m_done_owner;

  cnt_arb #(.WIDTH(W), .NREQ(N)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .req      (req),
    .model_in (model_in),
    .grant    (grant),
    .busy     (busy),
    .cnt      (cnt),
    .done     (done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset;
    sys_rst  = 1'b1;
    req      = '0;
    model_in = '0;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
  endtask

  task automatic model_reset;
    m_owner      = -1;
    m_k          = 0;
    m_mod        = 0;
    m_ptr        = N - 1;
    m_done_owner = -1;
  endtask

  // Job-level view: who owns the counter, how far along it is, and whose done is showing.
  task automatic model_step(input logic [N-1:0] r, input logic [N*W-1:0] mi);
    int c, s;
    if (m_done_owner >= 0) begin
      m_ptr        = m_done_owner;
      m_done_owner = -1;
    end else if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_ptr   = m_owner;
        m_owner = -1;
        m_k     = 0;
      end else if (m_k == m_mod - 1) begin
        m_done_owner = m_owner;
        m_owner      = -1;
        m_k          = 0;
      end else begin
        m_k = m_k + 1;
      end
    end else begin
      for (int j = 1; j <= N; j++) begin
        c = (m_ptr + j) % N;
        if (m_owner < 0 && r[c]) begin
          m_owner = c;
          s       = int'((mi >> (c * W)) & 16'hf);
          m_mod   = (s == 0) ? (1 << W) : s;
          m_k     = 0;
        end
      end
    end
  endtask

  task automatic test_reset;
    sys_rst = 1'b1;
    req     = 4'b1111;
    model_in = 16'h1111;
    @(posedge sys_clk);
    #1;
    n_tests++;
    if ({grant, done, busy, cnt} !== 13'b0) begin
      n_fail++;
      $display("FAIL reset_state: grant=%b done=%b busy=%b cnt=%0d want all zero", grant, done, busy, cnt);
    end
    sys_rst = 1'b0;
    tick;
    n_tests++;
    if (grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_first_winner: grant=%b want 0001", grant);
    end
  endtask

  task automatic test_single_job;
    do_reset;
    model_in = 16'h7a35;
    req      = 4'b0001;
    tick;
    n_tests++;
    if (grant !== 4'b0001 || cnt !== 4'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: grant=%b cnt=%0d busy=%b want 0001/0/1", grant, cnt, busy);
    end
    model_in = 16'hfff1;
    for (int i = 1; i <= 4; i++) begin
      tick;
      n_tests++;
      if (cnt !== 4'(i) || grant !== 4'b0001 || done !== 4'b0) begin
        n_fail++;
        $display("FAIL single_count: cnt=%0d grant=%b done=%b want %0d/0001/0000", cnt, grant, done, i);
      end
    end
    tick;
    n_tests++;
    if (done !== 4'b0001 || grant !== 4'b0 || cnt !== 4'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_done: done=%b grant=%b cnt=%0d busy=%b want 0001/0000/0/1", done, grant, cnt, busy);
    end
    req = '0;
    tick;
    n_tests++;
    if (done !== 4'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: done=%b busy=%b want 0000/0", done, busy);
    end
  endtask

  task automatic test_round_robin;
    logic [N-1:0] exp_g;
    do_reset;
    model_in = 16'h2222;
    req      = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      exp_g = 4'(1 << (j % N));
      tick;
      n_tests++;
      if (grant !== exp_g) begin
        n_fail++;
        $display("FAIL rr_grant: job %0d grant=%b want %b", j, grant, exp_g);
      end
      tick;
      tick;
      n_tests++;
      if (done !== exp_g || grant !== 4'b0) begin
        n_fail++;
        $display("FAIL rr_done: job %0d done=%b grant=%b want %b/0000", j, done, grant, exp_g);
      end
      tick;
      n_tests++;
      if (busy !== 1'b0 || grant !== 4'b0) begin
        n_fail++;
        $display("FAIL rr_gap: job %0d busy=%b grant=%b want 0/0000", j, busy, grant);
      end
    end
    req = '0;
  endtask

  task automatic test_mod_zero;
    do_reset;
    model_in = 16'h3067;
    req      = 4'b0100;
    tick;
    n_tests++;
    if (grant !== 4'b0100 || cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL mod0_grant: grant=%b cnt=%0d want 0100/0", grant, cnt);
    end
    for (int i = 1; i <= 15; i++) begin
      tick;
      n_tests++;
      if (cnt !== 4'(i) || grant !== 4'b0100 || done !== 4'b0) begin
        n_fail++;
        $display("FAIL mod0_count: cnt=%0d grant=%b done=%b want %0d/0100/0000", cnt, grant, done, i);
      end
    end
    tick;
    n_tests++;
    if (done !== 4'b0100 || cnt !== 4'd0 || grant !== 4'b0) begin
      n_fail++;
      $display("FAIL mod0_done: done=%b cnt=%0d grant=%b want 0100/0/0000", done, cnt, grant);
    end
    req = '0;
    tick;
  endtask

  task automatic test_mod_one;
    do_reset;
    model_in = 16'h4412;
    req      = 4'b0010;
    tick;
    n_tests++;
    if (grant !== 4'b0010 || cnt !== 4'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mod1_grant: grant=%b cnt=%0d busy=%b want 0010/0/1", grant, cnt, busy);
    end
    tick;
    n_tests++;
    if (done !== 4'b0010 || grant !== 4'b0) begin
      n_fail++;
      $display("FAIL mod1_done: done=%b grant=%b want 0010/0000", done, grant);
    end
    req = '0;
    tick;
    n_tests++;
    if (done !== 4'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mod1_idle: done=%b busy=%b want 0000/0", done, busy);
    end
  endtask

  task automatic test_abandon;
    do_reset;
    model_in = 16'h0036;
    req      = 4'b0011;
    tick;
    n_tests++;
    if (grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL abandon_grant: grant=%b want 0001", grant);
    end
    tick;
    tick;
    n_tests++;
    if (cnt !== 4'd2) begin
      n_fail++;
      $display("FAIL abandon_cnt: cnt=%0d want 2", cnt);
    end
    req = 4'b0010;
    tick;
    n_tests++;
    if ({grant, done, busy, cnt} !== 13'b0) begin
      n_fail++;
      $display("FAIL abandon_idle: grant=%b done=%b busy=%b cnt=%0d want all zero", grant, done, busy, cnt);
    end
    tick;
    n_tests++;
    if (grant !== 4'b0010 || done !== 4'b0) begin
      n_fail++;
      $display("FAIL abandon_next: grant=%b done=%b want 0010/0000", grant, done);
    end
    req = '0;
    tick;
  endtask

  task automatic test_async_reset;
    do_reset;
    model_in = 16'h0091;
    req      = 4'b0001;
    tick;
    tick;
    req = 4'b0010;
    tick;
    tick;
    n_tests++;
    if (grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL arst_pre_grant: grant=%b want 0010", grant);
    end
    tick;
    tick;
    tick;
    n_tests++;
    if (cnt !== 4'd3) begin
      n_fail++;
      $display("FAIL arst_pre_cnt: cnt=%0d want 3", cnt);
    end
    #2;
    sys_rst = 1'b1;
    #1;
    n_tests++;
    if ({grant, done, busy, cnt} !== 13'b0) begin
      n_fail++;
      $display("FAIL arst_clear: grant=%b done=%b busy=%b cnt=%0d want all zero", grant, done, busy, cnt);
    end
    #1;
    sys_rst = 1'b0;
    req     = 4'b1111;
    tick;
    n_tests++;
    if (grant !== 4'b0001 || done !== 4'b0) begin
      n_fail++;
      $display("FAIL arst_winner: grant=%b done=%b want 0001/0000", grant, done);
    end
    req = '0;
  endtask

  task automatic test_random;
    logic [N-1:0] exp_g, exp_d;
    logic         exp_b;
    do_reset;
    model_reset;
    req      = 4'($urandom);
    model_in = 16'($urandom);
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(posedge sys_clk);
      model_step(req, model_in);
      #1;
      exp_g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
      exp_d = (m_done_owner >= 0) ? 4'(1 << m_done_owner) : 4'b0;
      exp_b = (m_owner >= 0) || (m_done_owner >= 0);
      n_tests++;
      if (grant !== exp_g || done !== exp_d || busy !== exp_b || cnt !== 4'(m_k)) begin
        n_fail++;
        $display("FAIL random_cycle%0d: grant=%b done=%b busy=%b cnt=%0d want %b/%b/%b/%0d",
                 cyc, grant, done, busy, cnt, exp_g, exp_d, exp_b, m_k);
      end
      if ($urandom_range(0, 5) == 0) req = req ^ 4'(1 << $urandom_range(0, N - 1));
      model_in = 16'($urandom);
    end
    req = '0;
  endtask

  initial begin
    sys_rst  = 1'b1;
    req      = '0;
    model_in = '0;
    tick;
    test_reset;
    test_single_job;
    test_round_robin;
    test_mod_zero;
    test_mod_one;
    test_abandon;
    test_async_reset;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
